// File: rtl/vector_mul_pipe.sv
// vector_mul_pipe: two-stage pipelined WIDTHxWIDTH multiplier supporting
// MUL / MULH / MULHSU / MULHU, built from 17x17 signed limb products, with
// a collapsing valid/ready pipeline and a pass-through tag.

// 17x17 signed limb multiplier; the only multiply operator in the datapath.
module vproc_mul_block (
  input  logic signed [16:0] i_a,
  input  logic signed [16:0] i_b,
  output logic signed [33:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module vector_mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         in_op_i,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_result_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  localparam int unsigned N   = WIDTH / 16;
  localparam int unsigned NPP = N * N;
  localparam int unsigned PW  = 2 * WIDTH;
  // Sum width leaves room for a full 34-bit limb product even when WIDTH=16.
  localparam int unsigned SW  = PW + 34;

  logic                    w_a_sgn;
  logic                    w_b_sgn;
  logic signed [16:0]      w_a_limb [N];
  logic signed [16:0]      w_b_limb [N];
  logic signed [33:0]      w_pp     [NPP];
  logic                    w_s2_load;
  logic                    w_s1_load;
  logic [SW-1:0]           w_sum;
  logic [WIDTH-1:0]        w_res;

  logic                    r_s1_valid;
  logic [1:0]              r_s1_op;
  logic [TAG_W-1:0]        r_s1_tag;
  logic signed [33:0]      r_s1_pp  [NPP];
  logic                    r_s2_valid;
  logic [WIDTH-1:0]        r_s2_result;
  logic [TAG_W-1:0]        r_s2_tag;

  // Operand signedness by op: a is unsigned only for MULHU, b is signed for MUL/MULH.
  always_comb begin
    w_a_sgn = (in_op_i != 2'b11);
    w_b_sgn = (in_op_i[1] == 1'b0);
  end

  // Limb split: lower limbs zero-extended, top limb extended by operand sign.
  for (genvar i = 0; i < int'(N); i++) begin : g_limb
    if (i == int'(N) - 1) begin : g_top
      assign w_a_limb[i] = {w_a_sgn & in_a_i[WIDTH-1], in_a_i[16*i +: 16]};
      assign w_b_limb[i] = {w_b_sgn & in_b_i[WIDTH-1], in_b_i[16*i +: 16]};
    end else begin : g_low
      assign w_a_limb[i] = {1'b0, in_a_i[16*i +: 16]};
      assign w_b_limb[i] = {1'b0, in_b_i[16*i +: 16]};
    end
  end

  // N*N partial products, index i*N+j carries weight 2^(16*(i+j)).
  for (genvar i = 0; i < int'(N); i++) begin : g_pp_i
    for (genvar j = 0; j < int'(N); j++) begin : g_pp_j
      vproc_mul_block u_pp (
        .i_a (w_a_limb[i]),
        .i_b (w_b_limb[j]),
        .o_p (w_pp[i*int'(N)+j])
      );
    end
  end

  // Collapsing handshake: a stage loads when empty or when its successor moves.
  always_comb begin
    w_s2_load  = !r_s2_valid || out_ready_i;
    w_s1_load  = !r_s1_valid || w_s2_load;
    in_ready_o = rst_ni && w_s1_load;
  end

  // Stage 1 register: partial products, op, tag and valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 2'b00;
      r_s1_tag   <= '0;
      for (int k = 0; k < int'(NPP); k++) r_s1_pp[k] <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid_i;
        if (in_valid_i) begin
          r_s1_op  <= in_op_i;
          r_s1_tag <= in_tag_i;
          for (int k = 0; k < int'(NPP); k++) r_s1_pp[k] <= w_pp[k];
        end
      end
      if (flush_i) r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 combinational accumulate of shifted, sign-extended partial products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        w_sum = w_sum + (SW'(r_s1_pp[i*int'(N)+j]) << (16 * (i + j)));
      end
    end
    w_res = (r_s1_op == 2'b00) ? w_sum[WIDTH-1:0] : w_sum[PW-1:WIDTH];
  end

  // Stage 2 register: selected product half, tag and valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_res;
          r_s2_tag    <= r_s1_tag;
        end
      end
      if (flush_i) r_s2_valid <= 1'b0;
    end
  end

  assign out_valid_o  = r_s2_valid;
  assign out_result_o = r_s2_result;
  assign out_tag_o    = r_s2_tag;

endmodule

// File: tb/tb_vector_mul_pipe.sv
// Directed bench for vector_mul_pipe at WIDTH=32: table of mode/corner
// vectors plus hand-written backpressure, flush and reset sequences.
module tb_vector_mul_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t tbl [8];

  vector_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_tag_i     (in_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_tag_o    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full 64-bit product of extended operands, mod 2^64.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11)   ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Count cycles with out_valid over n cycles; expected to be zero after a kill.
  task automatic expect_silent(input string name, input int n);
    int hits;
    hits = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk(name, 64'(hits), 64'd0);
  endtask

  initial begin
    int sent, rx, cyc;
    vec_t bp [5];

    tbl[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 4'd0, 32'hFFFFFFFA};
    tbl[1] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 4'd1, 32'hFFFFFFFF};
    tbl[2] = '{2'b10, 32'hFFFFFFFE, 32'h00000003, 4'd2, 32'hFFFFFFFF};
    tbl[3] = '{2'b11, 32'hFFFFFFFE, 32'h00000003, 4'd3, 32'h00000002};
    tbl[4] = '{2'b01, 32'h80000000, 32'h80000000, 4'd4, 32'h40000000};
    tbl[5] = '{2'b00, 32'h80000000, 32'h80000000, 4'd5, 32'h00000000};
    tbl[6] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 32'hFFFFFFFE};
    tbl[7] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 32'h00000001};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);

    // Reset held for three cycles: every output reads zero.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({in_ready, out_valid, out_tag, out_result}), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // One op at a time: result visible after the second edge counting the accept.
    out_ready = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].tag);
      @(negedge clk);
      chk("tbl_in_ready", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      @(negedge clk);
      chk("tbl_not_early", 64'(out_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("tbl_valid", 64'(out_valid), 64'd1);
      chk("tbl_result", 64'(out_result), 64'(tbl[v].exp));
      chk("tbl_tag", 64'(out_tag), 64'(tbl[v].tag));
      tick();
    end

    // Back-to-back stream of the table: one op per cycle, no bubbles.
    rx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1'b1, tbl[c].op, tbl[c].a, tbl[c].b, tbl[c].tag);
      else       drive(1'b0, 2'b00, '0, '0, '0);
      @(negedge clk);
      if (c < 8) chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (out_valid && rx < 8) begin
        chk("stream_result", 64'(out_result), 64'(tbl[rx].exp));
        chk("stream_tag", 64'(out_tag), 64'(tbl[rx].tag));
        rx++;
      end
      tick();
    end
    chk("stream_count", 64'(rx), 64'd8);

    // Backpressure: five ops offered while the consumer stalls, then released.
    for (int k = 0; k < 5; k++) begin
      bp[k].op  = 2'(k % 4);
      bp[k].a   = 32'h11111111 * (k + 1) + 32'h7;
      bp[k].b   = 32'hF0F00000 + 32'(k * 977);
      bp[k].tag = 4'(k + 8);
      bp[k].exp = ref_mul(bp[k].op, bp[k].a, bp[k].b);
    end
    out_ready = 1'b0;
    sent = 0; rx = 0; cyc = 0;
    while (rx < 5 && cyc < 40) begin
      if (cyc == 8) out_ready = 1'b1;
      if (sent < 5) drive(1'b1, bp[sent].op, bp[sent].a, bp[sent].b, bp[sent].tag);
      else          drive(1'b0, 2'b00, '0, '0, '0);
      @(negedge clk);
      if (cyc == 7) begin
        chk("bp_accepts", 64'(sent), 64'd2);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      if (cyc < 8 && out_valid) begin
        chk("bp_hold_result", 64'(out_result), 64'(bp[0].exp));
        chk("bp_hold_tag", 64'(out_tag), 64'(bp[0].tag));
      end
      if (out_valid && out_ready) begin
        chk("bp_result", 64'(out_result), 64'(bp[rx].exp));
        chk("bp_tag", 64'(out_tag), 64'(bp[rx].tag));
        rx++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    chk("bp_received", 64'(rx), 64'd5);
    drive(1'b0, 2'b00, '0, '0, '0);
    expect_silent("bp_no_dup", 4);
    tick();

    // Flush with a full, stalled pipe: nothing may emerge.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd5, 32'd6, 4'hA);
    tick();
    drive(1'b1, 2'b00, 32'd7, 32'd8, 4'hB);
    tick();
    drive(1'b1, 2'b00, 32'd9, 32'd10, 4'hC);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    out_ready = 1'b1;
    expect_silent("flush_killed", 5);
    tick();
    drive(1'b1, 2'b01, 32'h12345678, 32'h9ABCDEF0, 4'hD);
    tick();
    drive(1'b0, 2'b00, '0, '0, '0);
    tick();
    @(negedge clk);
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_result", 64'(out_result), 64'(ref_mul(2'b01, 32'h12345678, 32'h9ABCDEF0)));
    chk("post_flush_tag", 64'(out_tag), 64'hD);
    tick();

    // Input accepted in the flush cycle is discarded.
    drive(1'b1, 2'b00, 32'd3, 32'd4, 4'h1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    expect_silent("flush_same_cycle", 4);
    tick();

    // Reset in flight drops the pending result.
    drive(1'b1, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 4'h2);
    tick();
    drive(1'b0, 2'b00, '0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    expect_silent("rst_mid_dropped", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
